// File: rtl/nested_isqrt_chain_fsm.sv
// ============================================================================
// nested_isqrt_chain_fsm : nested root chain over one shared external isqrt
// Revision: 1.0
// ============================================================================
`default_nettype none

module nested_isqrt_chain_fsm #(
   parameter int N_TERMS  = 3,
   parameter int W        = 32,
   parameter int YW       = W / 2,
   parameter int SATURATE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 arg_vld,
   output logic                 arg_rdy,
   input  logic [N_TERMS*W-1:0] args,
   output logic                 res_vld,
   output logic [YW-1:0]        res,
   output logic                 busy,
   output logic                 isqrt_x_vld,
   output logic [W-1:0]         isqrt_x,
   input  logic                 isqrt_y_vld,
   input  logic [YW-1:0]        isqrt_y
);

   localparam int              c_IW   = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
   localparam logic [c_IW-1:0] c_LAST = c_IW'(N_TERMS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t               r_state;
   logic [N_TERMS*W-1:0] r_args;
   logic [c_IW-1:0]      r_idx;
   logic [YW-1:0]        r_y;

   logic [W-1:0]         w_x;
   logic [W:0]           w_sum;
   logic [W-1:0]         w_fix;

   // Operand for the current step: innermost term goes in raw, outer terms
   // are summed with the previous root and clamped or wrapped on carry-out.
   always_comb begin
      w_x   = r_args[r_idx*W +: W];
      w_sum = {1'b0, w_x} + {{(W + 1 - YW){1'b0}}, r_y};
      if ((SATURATE != 0) && w_sum[W])
         w_fix = '1;
      else
         w_fix = w_sum[W-1:0];
   end

   assign isqrt_x = (r_idx == c_LAST) ? w_x : w_fix;
   assign arg_rdy = (r_state == IDLE);
   assign busy    = ~arg_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_args      <= '0;
         r_idx       <= '0;
         r_y         <= '0;
         res         <= '0;
         res_vld     <= 1'b0;
         isqrt_x_vld <= 1'b0;
      end else begin
         res_vld     <= 1'b0;
         isqrt_x_vld <= 1'b0;
         case (r_state)
            IDLE: begin
               if (arg_vld) begin
                  r_args      <= args;
                  r_idx       <= c_LAST;
                  r_state     <= ISSUE;
                  isqrt_x_vld <= 1'b1;
               end
            end
            ISSUE: begin
               r_state <= WAIT;
            end
            WAIT: begin
               if (isqrt_y_vld) begin
                  r_y <= isqrt_y;
                  if (r_idx == '0) begin
                     res     <= isqrt_y;
                     res_vld <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     r_idx       <= r_idx - 1'b1;
                     r_state     <= ISSUE;
                     isqrt_x_vld <= 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_nested_isqrt_chain_fsm.sv
// ============================================================================
// tb_nested_isqrt_chain_fsm : directed bench with a variable-latency isqrt model
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_nested_isqrt_chain_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        spur;
   logic        av  [4];
   logic [95:0] ag  [4];
   logic        rdy [4];
   logic        rv  [4];
   logic        bz  [4];
   logic        mxv [4];
   logic [15:0] rs  [4];
   logic [31:0] mx  [4];
   logic        my_vld [4];
   logic [15:0] my  [4];
   logic        yv3;

   wire [3:0]  rs1w, rs2w;
   wire [7:0]  x1w, x2w;

   int checks = 0;
   int errors = 0;

   // dut 0: N=3 W=32 saturating; 1/2: N=2 W=8 saturating/wrapping; 3: N=1
   nested_isqrt_chain_fsm #(.N_TERMS(3), .W(32), .SATURATE(1)) u_dut0 (
      .clk(clk), .rst(rst), .arg_vld(av[0]), .arg_rdy(rdy[0]), .args(ag[0]),
      .res_vld(rv[0]), .res(rs[0]), .busy(bz[0]), .isqrt_x_vld(mxv[0]),
      .isqrt_x(mx[0]), .isqrt_y_vld(my_vld[0]), .isqrt_y(my[0]));

   nested_isqrt_chain_fsm #(.N_TERMS(2), .W(8), .SATURATE(1)) u_dut1 (
      .clk(clk), .rst(rst), .arg_vld(av[1]), .arg_rdy(rdy[1]), .args(ag[1][15:0]),
      .res_vld(rv[1]), .res(rs1w), .busy(bz[1]), .isqrt_x_vld(mxv[1]),
      .isqrt_x(x1w), .isqrt_y_vld(my_vld[1]), .isqrt_y(my[1][3:0]));

   nested_isqrt_chain_fsm #(.N_TERMS(2), .W(8), .SATURATE(0)) u_dut2 (
      .clk(clk), .rst(rst), .arg_vld(av[2]), .arg_rdy(rdy[2]), .args(ag[2][15:0]),
      .res_vld(rv[2]), .res(rs2w), .busy(bz[2]), .isqrt_x_vld(mxv[2]),
      .isqrt_x(x2w), .isqrt_y_vld(my_vld[2]), .isqrt_y(my[2][3:0]));

   nested_isqrt_chain_fsm #(.N_TERMS(1), .W(32), .SATURATE(1)) u_dut3 (
      .clk(clk), .rst(rst), .arg_vld(av[3]), .arg_rdy(rdy[3]), .args(ag[3][31:0]),
      .res_vld(rv[3]), .res(rs[3]), .busy(bz[3]), .isqrt_x_vld(mxv[3]),
      .isqrt_x(mx[3]), .isqrt_y_vld(yv3), .isqrt_y(my[3]));

   assign rs[1] = {12'b0, rs1w};
   assign rs[2] = {12'b0, rs2w};
   assign mx[1] = {24'b0, x1w};
   assign mx[2] = {24'b0, x2w};
   assign yv3   = my_vld[3] | spur;

   function automatic logic [15:0] isq(input logic [31:0] x);
      longint r = 0;
      for (int b = 15; b >= 0; b--) begin
         longint t = r | (longint'(1) << b);
         if (t * t <= longint'(x)) r = t;
      end
      return r[15:0];
   endfunction

   // isqrt model: result appears lat_cfg cycles after the request cycle
   int          lat_cfg [4];
   int          nreq    [4] = '{0, 0, 0, 0};
   logic [31:0] rlog    [4][8];
   logic        pend    [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
   logic        pxv     [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
   int          cnt     [4];
   logic [15:0] hold    [4];
   int          wide_err = 0;
   int          ovl_err  = 0;

   always @(posedge clk) begin
      for (int d = 0; d < 4; d++) begin
         pxv[d]    <= mxv[d];
         my_vld[d] <= 1'b0;
         if (rst) begin
            pend[d] <= 1'b0;
         end else if (mxv[d]) begin
            if (pxv[d]) wide_err <= wide_err + 1;
            if (pend[d]) ovl_err <= ovl_err + 1;
            rlog[d][nreq[d] % 8] <= mx[d];
            nreq[d] <= nreq[d] + 1;
            if (lat_cfg[d] <= 1) begin
               my_vld[d] <= 1'b1;
               my[d]     <= isq(mx[d]);
            end else begin
               pend[d] <= 1'b1;
               cnt[d]  <= lat_cfg[d] - 1;
               hold[d] <= isq(mx[d]);
            end
         end else if (pend[d]) begin
            if (cnt[d] == 1) begin
               my_vld[d] <= 1'b1;
               my[d]     <= hold[d];
               pend[d]   <= 1'b0;
            end else begin
               cnt[d] <= cnt[d] - 1;
            end
         end
      end
   end

   // Drives one argument set and returns cycles from accept to res_vld.
   task automatic run_op(input int d, input logic [95:0] a, input int l,
                         output int lat, output logic [15:0] r, output int base);
      lat_cfg[d] = l;
      lat = -1;
      r   = '0;
      @(negedge clk);
      base  = nreq[d];
      av[d] = 1'b1;
      ag[d] = a;
      @(posedge clk);
      @(negedge clk);
      av[d] = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         if (rv[d]) begin
            lat = k;
            r   = rs[d];
            break;
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks += 5;
      if (rdy[0] !== 1'b1)   begin errors++; $display("FAIL reset_arg_rdy got %b want 1", rdy[0]); end
      if (bz[0] !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", bz[0]); end
      if (rv[0] !== 1'b0)    begin errors++; $display("FAIL reset_res_vld got %b want 0", rv[0]); end
      if (rs[0] !== 16'd0)   begin errors++; $display("FAIL reset_res got %0d want 0", rs[0]); end
      if (mxv[0] !== 1'b0)   begin errors++; $display("FAIL reset_x_vld got %b want 0", mxv[0]); end
      rst = 1'b0;
   endtask

   task automatic test_chain_l1;
      int lat, base;
      logic [15:0] r;
      run_op(0, {32'd0, 32'd16, 32'd12, 32'd5}, 1, lat, r, base);
      checks += 5;
      if (r !== 16'd3) begin errors++; $display("FAIL l1_res got %0d want 3", r); end
      if (lat != 7)    begin errors++; $display("FAIL l1_latency got %0d want 7", lat); end
      if (rlog[0][base % 8] !== 32'd16)       begin errors++; $display("FAIL l1_req0 got %0d want 16", rlog[0][base % 8]); end
      if (rlog[0][(base + 1) % 8] !== 32'd16) begin errors++; $display("FAIL l1_req1 got %0d want 16", rlog[0][(base + 1) % 8]); end
      if (rlog[0][(base + 2) % 8] !== 32'd9)  begin errors++; $display("FAIL l1_req2 got %0d want 9", rlog[0][(base + 2) % 8]); end
   endtask

   task automatic test_back_to_back;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rdy[0] !== 1'b1) begin errors++; $display("FAIL b2b_arg_rdy got %b want 1", rdy[0]); end
   endtask

   task automatic test_chain_l5;
      int lat, base;
      logic [15:0] r;
      run_op(0, {32'd0, 32'd16, 32'd12, 32'd5}, 5, lat, r, base);
      checks += 3;
      if (r !== 16'd3) begin errors++; $display("FAIL l5_res got %0d want 3", r); end
      if (lat != 19)   begin errors++; $display("FAIL l5_latency got %0d want 19", lat); end
      if (wide_err != 0) begin errors++; $display("FAIL l5_pulse_width got %0d wide pulses want 0", wide_err); end
   endtask

   task automatic test_overflow;
      int lat, base;
      logic [15:0] r;
      run_op(1, 96'h0000_FFFA, 1, lat, r, base);
      checks += 3;
      if (r !== 16'd15) begin errors++; $display("FAIL sat_res got %0d want 15", r); end
      if (lat != 5)     begin errors++; $display("FAIL sat_latency got %0d want 5", lat); end
      if (rlog[1][(base + 1) % 8] !== 32'd255) begin errors++; $display("FAIL sat_req1 got %0d want 255", rlog[1][(base + 1) % 8]); end
      run_op(2, 96'h0000_FFFA, 1, lat, r, base);
      checks += 2;
      if (r !== 16'd3) begin errors++; $display("FAIL wrap_res got %0d want 3", r); end
      if (rlog[2][(base + 1) % 8] !== 32'd9) begin errors++; $display("FAIL wrap_req1 got %0d want 9", rlog[2][(base + 1) % 8]); end
   endtask

   task automatic test_busy_ignore;
      int lat = -1;
      logic rdy_bad = 1'b0;
      logic [15:0] r = '0;
      logic got2 = 1'b0;
      lat_cfg[0] = 1;
      @(negedge clk);
      av[0] = 1'b1;
      ag[0] = {32'd0, 32'd16, 32'd12, 32'd5};
      @(posedge clk);
      @(negedge clk);
      ag[0] = {32'd0, 32'd4, 32'd2, 32'd14};
      for (int k = 1; k <= 100; k++) begin
         if (rv[0]) begin lat = k; r = rs[0]; break; end
         if (rdy[0] !== 1'b0) rdy_bad = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      checks += 3;
      if (rdy_bad)     begin errors++; $display("FAIL busy_arg_rdy got 1 want 0 while computing"); end
      if (r !== 16'd3) begin errors++; $display("FAIL busy_first_res got %0d want 3", r); end
      if (lat != 7)    begin errors++; $display("FAIL busy_latency got %0d want 7", lat); end
      @(posedge clk);
      @(negedge clk);
      checks += 2;
      if (mxv[0] !== 1'b1) begin errors++; $display("FAIL next_accept_x_vld got %b want 1", mxv[0]); end
      if (mx[0] !== 32'd4) begin errors++; $display("FAIL next_accept_x got %0d want 4", mx[0]); end
      av[0] = 1'b0;
      ag[0] = {32'd0, 32'd99, 32'd99, 32'd99};
      r = '0;
      for (int k = 1; k <= 100; k++) begin
         if (rv[0]) begin r = rs[0]; got2 = 1'b1; break; end
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (!got2 || r !== 16'd4) begin errors++; $display("FAIL second_set_res got %0d (seen %b) want 4", r, got2); end
   endtask

   task automatic test_reset_mid;
      int lat, base;
      logic [15:0] r;
      logic seen = 1'b0;
      lat_cfg[0] = 5;
      @(negedge clk);
      av[0] = 1'b1;
      ag[0] = {32'd0, 32'd16, 32'd12, 32'd5};
      @(posedge clk);
      @(negedge clk);
      av[0] = 1'b0;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks += 4;
      if (rdy[0] !== 1'b1) begin errors++; $display("FAIL rstmid_arg_rdy got %b want 1", rdy[0]); end
      if (bz[0] !== 1'b0)  begin errors++; $display("FAIL rstmid_busy got %b want 0", bz[0]); end
      if (rs[0] !== 16'd0) begin errors++; $display("FAIL rstmid_res got %0d want 0", rs[0]); end
      if (rv[0] !== 1'b0)  begin errors++; $display("FAIL rstmid_res_vld got %b want 0", rv[0]); end
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
         if (rv[0] !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL rstmid_stale_res_vld got 1 want 0"); end
      run_op(0, {32'd0, 32'd16, 32'd12, 32'd5}, 5, lat, r, base);
      checks += 2;
      if (r !== 16'd3) begin errors++; $display("FAIL rstmid_new_res got %0d want 3", r); end
      if (lat != 19)   begin errors++; $display("FAIL rstmid_new_latency got %0d want 19", lat); end
   endtask

   task automatic test_single_term;
      int lat, base;
      logic [15:0] r;
      lat_cfg[3] = 2;
      @(negedge clk);
      spur = 1'b1;
      @(posedge clk);
      @(negedge clk);
      spur = 1'b0;
      checks += 3;
      if (rdy[3] !== 1'b1) begin errors++; $display("FAIL spur_arg_rdy got %b want 1", rdy[3]); end
      if (rv[3] !== 1'b0)  begin errors++; $display("FAIL spur_res_vld got %b want 0", rv[3]); end
      if (rs[3] !== 16'd0) begin errors++; $display("FAIL spur_res got %0d want 0", rs[3]); end
      run_op(3, 96'd1000000, 2, lat, r, base);
      checks += 3;
      if (r !== 16'd1000) begin errors++; $display("FAIL n1_res got %0d want 1000", r); end
      if (lat != 4)       begin errors++; $display("FAIL n1_latency got %0d want 4", lat); end
      if (rlog[3][base % 8] !== 32'd1000000) begin errors++; $display("FAIL n1_req got %0d want 1000000", rlog[3][base % 8]); end
   endtask

   task automatic test_protocol;
      checks += 2;
      if (wide_err != 0) begin errors++; $display("FAIL x_vld_width got %0d wide pulses want 0", wide_err); end
      if (ovl_err != 0)  begin errors++; $display("FAIL outstanding got %0d overlapping requests want 0", ovl_err); end
   endtask

   initial begin
      rst  = 1'b1;
      spur = 1'b0;
      for (int d = 0; d < 4; d++) begin
         av[d]      = 1'b0;
         ag[d]      = '0;
         lat_cfg[d] = 1;
      end
      test_reset();
      test_chain_l1();
      test_back_to_back();
      test_chain_l5();
      test_overflow();
      test_busy_ignore();
      test_reset_mid();
      test_single_term();
      test_protocol();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
